// File: rtl/decode_queue_stage.sv
// Decode-stage instruction queue: show-ahead FIFO feeding execute, with load-use stall and flush.
// Optional same-cycle fetch->execute bypass into an empty queue is enabled by DECODE_BYPASS_EN.
module decode_queue_stage #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned PKT_W    = 128,
  localparam int unsigned PTR_W   = $clog2(IQ_DEPTH),
  localparam int unsigned CNT_W   = $clog2(IQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [PKT_W-1:0] f_pkt,
  input  logic [4:0]       f_rs1,
  input  logic [4:0]       f_rs2,
  input  logic [4:0]       f_rd,
  input  logic             f_use_rs1,
  input  logic             f_use_rs2,
  input  logic             flush,
  input  logic             e_valid,
  input  logic             e_is_load,
  input  logic [4:0]       e_rd,
  input  logic             e_ready,
  output logic             d_valid,
  output logic [PKT_W-1:0] d_pkt,
  output logic [4:0]       d_rs1,
  output logic [4:0]       d_rs2,
  output logic [4:0]       d_rd,
  output logic [CNT_W-1:0] d_count
);

  logic [PKT_W-1:0] pkt_mem_q  [IQ_DEPTH];
  logic [4:0]       rs1_mem_q  [IQ_DEPTH];
  logic [4:0]       rs2_mem_q  [IQ_DEPTH];
  logic [4:0]       rd_mem_q   [IQ_DEPTH];
  logic             use1_mem_q [IQ_DEPTH];
  logic             use2_mem_q [IQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty, full, e_load_hit, head_hazard, q_valid;
  logic byp_take, push, pop;

  // Load in execute whose non-zero destination feeds a source this instruction actually reads
  function automatic logic load_use(input logic hit, input logic [4:0] erd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic u1, input logic u2);
    return hit & ((u1 & (erd == rs1)) | (u2 & (erd == rs2)));
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(IQ_DEPTH));
  assign e_load_hit  = e_valid & e_is_load & (e_rd != 5'd0);
  assign head_hazard = load_use(e_load_hit, e_rd, rs1_mem_q[rd_ptr_q], rs2_mem_q[rd_ptr_q],
                                use1_mem_q[rd_ptr_q], use2_mem_q[rd_ptr_q]);
  assign q_valid     = rst_n & !empty & !head_hazard & !flush;
  assign f_ready     = rst_n & !full & !flush;
  assign d_count     = count_q;

`ifdef DECODE_BYPASS_EN
  logic byp_valid;

  assign byp_valid = rst_n & empty & f_valid & !flush &
                     !load_use(e_load_hit, e_rd, f_rs1, f_rs2, f_use_rs1, f_use_rs2);
  assign byp_take  = byp_valid & e_ready;

  // Empty queue: present the fetch fields directly; otherwise the head entry
  always_comb begin
    d_valid = q_valid;
    d_pkt   = pkt_mem_q[rd_ptr_q];
    d_rs1   = rs1_mem_q[rd_ptr_q];
    d_rs2   = rs2_mem_q[rd_ptr_q];
    d_rd    = rd_mem_q[rd_ptr_q];
    if (byp_valid) begin
      d_valid = 1'b1;
      d_pkt   = f_pkt;
      d_rs1   = f_rs1;
      d_rs2   = f_rs2;
      d_rd    = f_rd;
    end
  end
`else
  assign byp_take = 1'b0;
  assign d_valid  = q_valid;
  assign d_pkt    = pkt_mem_q[rd_ptr_q];
  assign d_rs1    = rs1_mem_q[rd_ptr_q];
  assign d_rs2    = rs2_mem_q[rd_ptr_q];
  assign d_rd     = rd_mem_q[rd_ptr_q];
`endif

  // A bypassed instruction consumed by execute is never enqueued
  assign push = f_valid & f_ready & !byp_take;
  assign pop  = q_valid & e_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      pkt_mem_q[wr_ptr_q]  <= f_pkt;
      rs1_mem_q[wr_ptr_q]  <= f_rs1;
      rs2_mem_q[wr_ptr_q]  <= f_rs2;
      rd_mem_q[wr_ptr_q]   <= f_rd;
      use1_mem_q[wr_ptr_q] <= f_use_rs1;
      use2_mem_q[wr_ptr_q] <= f_use_rs2;
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Self-checking bench for decode_queue_stage: queue-based reference model checked every negedge,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_decode_queue_stage;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [127:0] pkt;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         u1;
    logic         u2;
  } entry_t;

  logic         clk, rst_n;
  logic         f_valid, f_ready;
  logic [127:0] f_pkt;
  logic [4:0]   f_rs1, f_rs2, f_rd;
  logic         f_use_rs1, f_use_rs2;
  logic         flush, e_valid, e_is_load, e_ready;
  logic [4:0]   e_rd;
  logic         d_valid;
  logic [127:0] d_pkt;
  logic [4:0]   d_rs1, d_rs2, d_rd;
  logic [2:0]   d_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_retired = 0;
  entry_t mq[$];

  decode_queue_stage #(.IQ_DEPTH(DEPTH), .PKT_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_ready(f_ready), .f_pkt(f_pkt),
    .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd),
    .f_use_rs1(f_use_rs1), .f_use_rs2(f_use_rs2),
    .flush(flush), .e_valid(e_valid), .e_is_load(e_is_load), .e_rd(e_rd), .e_ready(e_ready),
    .d_valid(d_valid), .d_pkt(d_pkt), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_count(d_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2);
    if (!(e_valid && e_is_load) || e_rd == 5'd0) return 1'b0;
    return (u1 && e_rd == rs1) || (u2 && e_rd == rs2);
  endfunction

  // Reference model: expected outputs from the queue contents, then apply this cycle's transfer
  always @(negedge clk) begin : cmp
    entry_t h, inc;
    bit     ev, byp, exp_fr, do_push, do_pop;
    int     sz;
    sz = mq.size();
    inc.pkt = f_pkt; inc.rs1 = f_rs1; inc.rs2 = f_rs2; inc.rd = f_rd;
    inc.u1 = f_use_rs1; inc.u2 = f_use_rs2;
    if (!rst_n) begin
      chk("rst_f_ready", 128'(f_ready), 128'(0));
      chk("rst_d_valid", 128'(d_valid), 128'(0));
      chk("rst_d_count", 128'(d_count), 128'(0));
      mq.delete();
    end else begin
      exp_fr = (sz < DEPTH) && !flush;
      ev  = 1'b0;
      byp = 1'b0;
      h   = inc;
      if (sz > 0) begin
        h  = mq[0];
        ev = !hazard(h.rs1, h.rs2, h.u1, h.u2) && !flush;
      end
`ifdef DECODE_BYPASS_EN
      if (sz == 0 && f_valid && !flush && !hazard(f_rs1, f_rs2, f_use_rs1, f_use_rs2)) begin
        byp = 1'b1;
        ev  = 1'b1;
        h   = inc;
      end
`endif
      chk("f_ready", 128'(f_ready), 128'(exp_fr));
      chk("d_valid", 128'(d_valid), 128'(ev));
      chk("d_count", 128'(d_count), 128'(sz));
      if (ev) begin
        chk("d_pkt", d_pkt, h.pkt);
        chk("d_rs1", 128'(d_rs1), 128'(h.rs1));
        chk("d_rs2", 128'(d_rs2), 128'(h.rs2));
        chk("d_rd",  128'(d_rd),  128'(h.rd));
      end
      if (flush) begin
        mq.delete();
      end else begin
        do_pop  = ev && e_ready;
        do_push = f_valid && exp_fr && !(byp && e_ready);
        if (do_pop && !byp) void'(mq.pop_front());
        if (do_pop) n_retired++;
        if (do_push) begin
          mq.push_back(inc);
          n_pushed++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [127:0] p, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd, input logic u1, input logic u2);
    f_valid = 1'b1; f_pkt = p; f_rs1 = r1; f_rs2 = r2; f_rd = rdd;
    f_use_rs1 = u1; f_use_rs2 = u2;
  endtask

  // Offer one instruction and hold it until the queue takes it (bounded)
  task automatic push_one(input logic [127:0] p);
    bit acc;
    set_f(p, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      #2;
      acc = f_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("push_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_pkt = '0; f_rs1 = '0; f_rs2 = '0; f_rd = '0;
    f_use_rs1 = 1'b0; f_use_rs2 = 1'b0; flush = 1'b0;
    e_valid = 1'b0; e_is_load = 1'b0; e_rd = '0; e_ready = 1'b0;
    repeat (2) cyc();
    chk("lit_rst_f_ready", 128'(f_ready), 128'(0));
    chk("lit_rst_d_count", 128'(d_count), 128'(0));
    rst_n = 1'b1;
    cyc();

    // 1: back-to-back A,B,C with execute always ready
    e_ready = 1'b1;
    set_f(128'hA, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    set_f(128'hB, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
`ifndef DECODE_BYPASS_EN
    #2;
    chk("lit_t1_valid_a", 128'(d_valid), 128'(1));
    chk("lit_t1_pkt_a", d_pkt, 128'hA);
    chk("lit_t1_count_a", 128'(d_count), 128'(1));
`endif
    cyc();
    set_f(128'hC, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
`ifndef DECODE_BYPASS_EN
    #2;
    chk("lit_t1_pkt_b", d_pkt, 128'hB);
`endif
    cyc();
    f_valid = 1'b0;
`ifndef DECODE_BYPASS_EN
    #2;
    chk("lit_t1_pkt_c", d_pkt, 128'hC);
    chk("lit_t1_count_c", 128'(d_count), 128'(1));
`endif
    cyc();
    #2;
    chk("lit_t1_empty", 128'(d_count), 128'(0));
    cyc();

    // 2: fill to depth with execute stalled, fifth held until a pop
    e_ready = 1'b0;
    push_one(128'h1A);
    push_one(128'h1B);
    push_one(128'h1C);
    push_one(128'h1D);
    set_f(128'h1E, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #2;
    chk("lit_t2_full_count", 128'(d_count), 128'(4));
    chk("lit_t2_full_ready", 128'(f_ready), 128'(0));
    chk("lit_t2_head", d_pkt, 128'h1A);
    cyc();
    e_ready = 1'b1;
    #2;
    chk("lit_t2_still_full", 128'(f_ready), 128'(0));
    cyc();
    #2;
    chk("lit_t2_ready_after_pop", 128'(f_ready), 128'(1));
    chk("lit_t2_head_b", d_pkt, 128'h1B);
    cyc();
    f_valid = 1'b0;
    repeat (5) cyc();
    #2;
    chk("lit_t2_drained", 128'(d_count), 128'(0));
    cyc();

    // 3: load-use stall on rs1, then the no-stall cases
    e_valid = 1'b1; e_is_load = 1'b1; e_rd = 5'd5; e_ready = 1'b1;
    set_f(128'h31, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0);
    cyc();
    f_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lit_t3_stall", 128'(d_valid), 128'(0));
      cyc();
    end
    e_valid = 1'b0;
    #2;
    chk("lit_t3_release", 128'(d_valid), 128'(1));
    cyc();
    e_valid = 1'b1; e_rd = 5'd0;
    set_f(128'h32, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
    e_ready = 1'b0;
    cyc();
    f_valid = 1'b0;
    #2;
    chk("lit_t3_rd_x0", 128'(d_valid), 128'(1));
    e_ready = 1'b1;
    cyc();
    e_rd = 5'd5;
    set_f(128'h33, 5'd5, 5'd3, 5'd1, 1'b0, 1'b1);
    e_ready = 1'b0;
    cyc();
    f_valid = 1'b0;
    #2;
    chk("lit_t3_no_use", 128'(d_valid), 128'(1));
    e_ready = 1'b1;
    cyc();
    e_rd = 5'd7;
    set_f(128'h34, 5'd1, 5'd7, 5'd2, 1'b0, 1'b1);
    cyc();
    f_valid = 1'b0;
    #2;
    chk("lit_t3_rs2_stall", 128'(d_valid), 128'(0));
    cyc();
    e_is_load = 1'b0;
    #2;
    chk("lit_t3_not_load", 128'(d_valid), 128'(1));
    cyc();
    e_valid = 1'b0;
    cyc();

    // 4: flush with three queued, fetch offering and execute ready
    e_ready = 1'b0;
    push_one(128'h41);
    push_one(128'h42);
    push_one(128'h43);
    set_f(128'h44, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    e_ready = 1'b1;
    flush = 1'b1;
    #2;
    chk("lit_t4_flush_ready", 128'(f_ready), 128'(0));
    chk("lit_t4_flush_valid", 128'(d_valid), 128'(0));
    chk("lit_t4_flush_count", 128'(d_count), 128'(3));
    cyc();
    flush = 1'b0; f_valid = 1'b0; e_ready = 1'b0;
    #2;
    chk("lit_t4_after_count", 128'(d_count), 128'(0));
    chk("lit_t4_after_valid", 128'(d_valid), 128'(0));
    cyc();

    // 5: random traffic, hazards and occasional flush
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 4) != 0)
        set_f({$urandom, $urandom, $urandom, $urandom}, 5'($urandom % 8), 5'($urandom % 8),
              5'($urandom % 32), 1'($urandom), 1'($urandom));
      else
        f_valid = 1'b0;
      e_ready   = (($urandom % 3) != 0);
      e_valid   = (($urandom % 2) != 0);
      e_is_load = (($urandom % 2) != 0);
      e_rd      = 5'($urandom % 8);
      flush     = (($urandom % 40) == 0);
      cyc();
    end
    f_valid = 1'b0; flush = 1'b0; e_valid = 1'b0; e_ready = 1'b1;
    repeat (6) cyc();
    #2;
    chk("lit_t5_drained", 128'(d_count), 128'(0));
    cyc();

    // 6: asynchronous reset mid-stream, then restart
    e_ready = 1'b0;
    push_one(128'h61);
    push_one(128'h62);
    f_valid = 1'b0;
    #1;
    chk("lit_t6_pre_valid", 128'(d_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("lit_t6_rst_valid", 128'(d_valid), 128'(0));
    chk("lit_t6_rst_count", 128'(d_count), 128'(0));
    cyc();
    rst_n = 1'b1;
    set_f(128'h63, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    f_valid = 1'b0;
    #2;
    chk("lit_t6_first_valid", 128'(d_valid), 128'(1));
    chk("lit_t6_first_pkt", d_pkt, 128'h63);
    e_ready = 1'b1;
    cyc();
`ifdef DECODE_BYPASS_EN
    set_f(128'h64, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #2;
    chk("lit_t6_byp_valid", 128'(d_valid), 128'(1));
    chk("lit_t6_byp_pkt", d_pkt, 128'h64);
    chk("lit_t6_byp_count", 128'(d_count), 128'(0));
    cyc();
    f_valid = 1'b0;
`endif
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
